axi_llc_flush_ctrl: RTL and testbench
=====================================

AXI_LLC_FLUSH_CTRL -- requirements
Module: axi_llc_flush_ctrl

Interface
REQ-001 SHALL have parameter AxiLiteAddrWidth, default 32, config-port address width.
REQ-002 SHALL have parameter AxiLiteDataWidth, default 32, config-port data width; 32 or 64 only.
REQ-003 SHALL have parameter SetAssociativity, default 8, number of LLC ways (<= AxiLiteDataWidth).
REQ-004 SHALL have parameter CfgFlushOffset, default 'h10, byte address of LLC flush-request register.
REQ-005 SHALL have parameter CfgFlushedOffset, default 'h18, byte address of LLC flushed-status register.
REQ-006 SHALL have parameter PollGap, default 16, idle cycles between status reads (>= 1).
REQ-007 SHALL have parameter MaxPolls, default 1024, poll limit (used only with REQ-031).
REQ-008 SHALL have type parameters lite_req_t / lite_resp_t, the AXI-Lite request/response structs of the LLC config port.
REQ-009 clk_i  in  1  single clock, all logic rising-edge.
REQ-010 rst_i  in  1  reset, asynchronous, active-high.
REQ-011 start_i  in  1  request one flush of the ways in way_mask_i; sampled only in IDLE.
REQ-012 way_mask_i  in  SetAssociativity  ways to flush, captured on accepted start_i.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 done_o  out  1  one-cycle pulse: all requested ways reported flushed.
REQ-015 err_o  out  1  one-cycle pulse: SLVERR/DECERR response (or timeout, REQ-031).
REQ-016 conf_req_o  out  lite_req_t  AXI-Lite master request to LLC config slave.
REQ-017 conf_resp_i  in  lite_resp_t  AXI-Lite response from LLC config slave.

Function
REQ-018 FSM states SHALL be IDLE, WR, WAIT_B, GAP, RD, WAIT_R, FIN.
REQ-019 IDLE: start_i=1 with nonzero mask -> capture mask, go WR; zero mask -> FIN directly, no bus traffic.
REQ-020 WR: aw_valid and w_valid asserted together, aw.addr=CfgFlushOffset, w.data=zero-extended mask, w.strb all-ones; each valid drops independently after its own handshake; both done -> WAIT_B.
REQ-021 Valid signals SHALL never deassert before their ready; payload SHALL be stable while valid.
REQ-022 WAIT_B: b_ready=1; on b_valid, resp OKAY -> GAP, else err_o pulse, -> IDLE.
REQ-023 GAP: count PollGap cycles, then RD.
REQ-024 RD: ar_valid=1, ar.addr=CfgFlushedOffset until ar_ready -> WAIT_R.
REQ-025 WAIT_R: r_ready=1; on r_valid: resp not OKAY -> err_o, IDLE; (r.data & mask)==mask -> FIN; else GAP.
REQ-026 FIN: done_o=1 for exactly one cycle, -> IDLE; start_i in same cycle ignored.
REQ-027 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-028 aw/w/ar prot fields SHALL be 0; at most one outstanding transaction at any time.

Reset
REQ-029 On rst_i: state IDLE, all valids/readies 0, busy_o/done_o/err_o 0, counters and captured mask 0; mid-transaction reset abandons the transaction with no completion pulse.

Configuration
REQ-030 Macro AXI_LLC_FLUSH_TIMEOUT_EN SHALL compile in poll-timeout logic.
REQ-031 With macro: poll counter increments per status read; MaxPolls reads without completion -> err_o pulse, IDLE. Without macro: polls indefinitely, no counter, MaxPolls unused.

Structure
REQ-032 Package axi_llc_flush_pkg SHALL hold the FSM state enum and default offset constants.
REQ-033 Single module; no sub-module needed.

Verification
REQ-034 mask=8'h0F, slave B OKAY, first read returns 'h0F -> one AW to 'h10 data 'h0F, one AR to 'h18, done_o pulse, busy_o low next cycle.
REQ-035 mask=8'hFF, reads return 'h01, 'h7F, 'hFF -> three ARs each spaced >= 16 idle cycles, done_o after third R.
REQ-036 aw_ready delayed 5 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid holds stable 6 cycles, single B accepted.
REQ-037 B resp SLVERR -> err_o pulse, no AR issued, IDLE; R resp DECERR -> err_o pulse.
REQ-038 mask=0 -> done_o 1 cycle after start, no valids asserted; start_i during busy -> ignored.
REQ-039 rst_i asserted while ar_valid=1 -> all outputs 0 immediately; with AXI_LLC_FLUSH_TIMEOUT_EN, MaxPolls=4, reads never complete -> err_o after 4th R.

Source files
------------

// File: rtl/axi_llc_flush_pkg.sv
// Shared types for the LLC flush controller: FSM state, default register offsets
// and the 32-bit AXI-Lite request/response structs of the LLC config port.
package axi_llc_flush_pkg;

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, GAP, RD, WAIT_R, FIN} flush_state_e;

    localparam logic [31:0] DefFlushOffset   = 32'h10;
    localparam logic [31:0] DefFlushedOffset = 32'h18;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } lite_r_t;

    typedef struct packed {
        lite_ax_t aw;
        logic     aw_valid;
        lite_w_t  w;
        logic     w_valid;
        logic     b_ready;
        lite_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        lite_b_t b;
        logic    b_valid;
        logic    ar_ready;
        lite_r_t r;
        logic    r_valid;
    } axi_lite_resp_t;

endpackage

// File: rtl/axi_llc_flush_ctrl_if.sv
// AXI-Lite config-port bundle between the flush controller (master) and the LLC
// config slave.
interface axi_llc_flush_ctrl_if
    import axi_llc_flush_pkg::*;
#(
    parameter type req_t  = axi_lite_req_t,
    parameter type resp_t = axi_lite_resp_t
);
    req_t  conf_req;
    resp_t conf_resp;

    modport master (output conf_req, input  conf_resp);
    modport slave  (input  conf_req, output conf_resp);
endinterface

// File: rtl/axi_llc_flush_ctrl.sv
// Requests an LLC way flush over AXI-Lite, then polls the flushed-status register
// until all requested ways report done. Define AXI_LLC_FLUSH_TIMEOUT_EN to bound polling.
module axi_llc_flush_ctrl
    import axi_llc_flush_pkg::*;
#(
    parameter int unsigned                 AxiLiteAddrWidth = 32,
    parameter int unsigned                 AxiLiteDataWidth = 32,
    parameter int unsigned                 SetAssociativity = 8,
    parameter logic [AxiLiteAddrWidth-1:0] CfgFlushOffset   = AxiLiteAddrWidth'(DefFlushOffset),
    parameter logic [AxiLiteAddrWidth-1:0] CfgFlushedOffset = AxiLiteAddrWidth'(DefFlushedOffset),
    parameter int unsigned                 PollGap          = 16,
    parameter int unsigned                 MaxPolls         = 1024,
    parameter type                         lite_req_t       = axi_lite_req_t,
    parameter type                         lite_resp_t      = axi_lite_resp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SetAssociativity-1:0] way_mask_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output lite_req_t                   conf_req_o,
    input  lite_resp_t                  conf_resp_i
);

    localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

    flush_state_e                state_q, state_d;
    logic [SetAssociativity-1:0] mask_q, mask_d;
    logic                        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [GapW-1:0]             gap_q, gap_d;
    logic                        err_q, err_d;
    logic                        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                        all_flushed, poll_limit;
    logic                        unused_resp;

    assign aw_hs = conf_req_o.aw_valid & conf_resp_i.aw_ready;
    assign w_hs  = conf_req_o.w_valid  & conf_resp_i.w_ready;
    assign b_hs  = conf_req_o.b_ready  & conf_resp_i.b_valid;
    assign ar_hs = conf_req_o.ar_valid & conf_resp_i.ar_ready;
    assign r_hs  = conf_req_o.r_ready  & conf_resp_i.r_valid;

    assign all_flushed = (conf_resp_i.r.data[SetAssociativity-1:0] & mask_q) == mask_q;
    assign unused_resp = ^conf_resp_i;

`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
    localparam int unsigned PollW = $clog2(MaxPolls + 1);
    logic [PollW-1:0] poll_q, poll_d;

    // Counts completed status reads of the current flush; cleared while idle.
    always_comb begin
        poll_d = poll_q;
        if (state_q == IDLE) poll_d = '0;
        else if (r_hs)       poll_d = poll_q + PollW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) poll_q <= '0;
        else       poll_q <= poll_d;
    end

    assign poll_limit = (poll_q == PollW'(MaxPolls - 1));
`else
    localparam int unsigned UnusedMaxPolls = MaxPolls;
    assign poll_limit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            gap_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        gap_d     = gap_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                if (|way_mask_i) begin
                    mask_d    = way_mask_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR;
                end else begin
                    state_d = FIN;
                end
            end
            // AW and W may complete in either order or together.
            WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WAIT_B;
            end
            WAIT_B: if (b_hs) begin
                if (conf_resp_i.b.resp == RespOkay) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == GapW'(PollGap - 1)) begin
                    gap_d   = '0;
                    state_d = RD;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            RD: if (ar_hs) state_d = WAIT_R;
            WAIT_R: if (r_hs) begin
                if (conf_resp_i.r.resp != RespOkay) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (all_flushed) begin
                    state_d = FIN;
                end else if (poll_limit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valids and readies decode from registered state only; payload is constant per flush.
    always_comb begin
        conf_req_o          = '0;
        conf_req_o.aw.addr  = CfgFlushOffset;
        conf_req_o.w.data   = AxiLiteDataWidth'(mask_q);
        conf_req_o.w.strb   = '1;
        conf_req_o.ar.addr  = CfgFlushedOffset;
        busy_o              = (state_q != IDLE);
        done_o              = (state_q == FIN);
        err_o               = err_q;
        unique case (state_q)
            WR: begin
                conf_req_o.aw_valid = ~aw_done_q;
                conf_req_o.w_valid  = ~w_done_q;
            end
            WAIT_B:  conf_req_o.b_ready  = 1'b1;
            RD:      conf_req_o.ar_valid = 1'b1;
            WAIT_R:  conf_req_o.r_ready  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_llc_flush_ctrl.sv
// Scoreboard bench for axi_llc_flush_ctrl: directed flushes against a small AXI-Lite
// slave model; a monitor checks every bus handshake and status pulse against a queue.
`timescale 1ns/1ps
module tb_axi_llc_flush_ctrl;
    import axi_llc_flush_pkg::*;

    localparam int EV_AW = 0, EV_W = 1, EV_AR = 2, EV_DONE = 3, EV_ERR = 4;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] mask;
    logic       busy, done, err;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    ev_t         exp_q[$];
    int          ar_cyc_q[$];
    logic [31:0] rdata_q[$];
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_cfg = RespOkay, r_resp_cfg = RespOkay;

    axi_llc_flush_ctrl_if bus ();

    axi_llc_flush_ctrl #(
        .MaxPolls    (4),
        .lite_req_t  (axi_lite_req_t),
        .lite_resp_t (axi_lite_resp_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .way_mask_i  (mask),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .conf_req_o  (bus.conf_req),
        .conf_resp_i (bus.conf_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic obs(input int k, input logic [31:0] v, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: got 'h%0h expected no event", name, v);
        end else begin
            e = exp_q.pop_front();
            chk({"ev_kind_", name}, k, e.kind);
            if (k == e.kind) chk({"ev_val_", name}, v, e.val);
        end
    endtask

    // Monitor: handshakes, pulses and protocol stability, sampled on the falling edge.
    initial begin
        axi_lite_req_t  q, pq;
        axi_lite_resp_t r;
        logic p_aw, p_w, p_ar;
        p_aw = 0; p_w = 0; p_ar = 0; pq = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                p_aw = 0; p_w = 0; p_ar = 0;
                continue;
            end
            q = bus.conf_req;
            r = bus.conf_resp;
            if (p_aw) begin chk("aw_hold", q.aw_valid, 1); chk("aw_addr_stable", q.aw.addr, pq.aw.addr); end
            if (p_w)  begin chk("w_hold", q.w_valid, 1);   chk("w_data_stable", q.w.data, pq.w.data);    end
            if (p_ar) begin chk("ar_hold", q.ar_valid, 1); chk("ar_addr_stable", q.ar.addr, pq.ar.addr); end
            if (q.aw_valid) chk("aw_prot", q.aw.prot, 0);
            if (q.ar_valid) begin
                chk("ar_prot", q.ar.prot, 0);
                chk("one_outstanding", {q.aw_valid, q.w_valid, q.b_ready, q.r_ready}, 0);
            end
            if (q.aw_valid && r.aw_ready) obs(EV_AW, q.aw.addr, "aw");
            if (q.w_valid && r.w_ready) begin
                obs(EV_W, q.w.data, "w");
                chk("w_strb", q.w.strb, 4'hF);
            end
            if (q.ar_valid && r.ar_ready) begin
                obs(EV_AR, q.ar.addr, "ar");
                ar_cyc_q.push_back(cyc);
            end
            if (done) obs(EV_DONE, 0, "done");
            if (err)  obs(EV_ERR, 0, "err");
            pq   = q;
            p_aw = q.aw_valid & ~r.aw_ready;
            p_w  = q.w_valid  & ~r.w_ready;
            p_ar = q.ar_valid & ~r.ar_ready;
        end
    end

    // AXI-Lite config slave model with programmable ready delays and responses.
    initial begin
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got;
        int   aw_cnt, w_cnt, ar_cnt;
        bus.conf_resp = '0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        forever begin
            @(negedge clk);
            hs_aw = bus.conf_req.aw_valid & bus.conf_resp.aw_ready;
            hs_w  = bus.conf_req.w_valid  & bus.conf_resp.w_ready;
            hs_b  = bus.conf_req.b_ready  & bus.conf_resp.b_valid;
            hs_ar = bus.conf_req.ar_valid & bus.conf_resp.ar_ready;
            hs_r  = bus.conf_req.r_ready  & bus.conf_resp.r_valid;
            @(posedge clk);
            #1;
            if (rst !== 1'b0) begin
                bus.conf_resp = '0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                continue;
            end
            if (hs_aw) aw_got = 1;
            if (hs_w)  w_got  = 1;
            if (hs_b)  bus.conf_resp.b_valid = 1'b0;
            if (hs_r)  bus.conf_resp.r_valid = 1'b0;
            if (aw_got && w_got && !bus.conf_resp.b_valid) begin
                bus.conf_resp.b_valid = 1'b1;
                bus.conf_resp.b.resp  = b_resp_cfg;
                aw_got = 0; w_got = 0;
            end
            if (hs_ar) begin
                bus.conf_resp.r_valid = 1'b1;
                bus.conf_resp.r.resp  = r_resp_cfg;
                bus.conf_resp.r.data  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
            end
            if (bus.conf_req.aw_valid && !hs_aw) begin
                if (aw_cnt >= aw_delay) bus.conf_resp.aw_ready = 1'b1;
                else begin aw_cnt++; bus.conf_resp.aw_ready = 1'b0; end
            end else begin bus.conf_resp.aw_ready = 1'b0; aw_cnt = 0; end
            if (bus.conf_req.w_valid && !hs_w) begin
                if (w_cnt >= w_delay) bus.conf_resp.w_ready = 1'b1;
                else begin w_cnt++; bus.conf_resp.w_ready = 1'b0; end
            end else begin bus.conf_resp.w_ready = 1'b0; w_cnt = 0; end
            if (bus.conf_req.ar_valid && !hs_ar) begin
                if (ar_cnt >= ar_delay) bus.conf_resp.ar_ready = 1'b1;
                else begin ar_cnt++; bus.conf_resp.ar_ready = 1'b0; end
            end else begin bus.conf_resp.ar_ready = 1'b0; ar_cnt = 0; end
        end
    end

    task automatic cfg(input int awd, input int wd, input int ard, input logic [1:0] br, input logic [1:0] rr);
        aw_delay = awd; w_delay = wd; ar_delay = ard; b_resp_cfg = br; r_resp_cfg = rr;
    endtask

    task automatic kick(input logic [7:0] m);
        @(posedge clk); #1;
        start = 1'b1;
        mask  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs until done/err; optionally pulses start mid-flight with a different mask.
    task automatic run(input int poke, output int aw_hi, output int w_hi, output int b_hs,
                       output int any_v, output int cycles, output logic got_done, output logic got_err);
        aw_hi = 0; w_hi = 0; b_hs = 0; any_v = 0; cycles = 0; got_done = 0; got_err = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == poke)     begin start = 1'b1; mask = 8'hF0; end
            if (i == poke + 1) start = 1'b0;
            aw_hi += int'(bus.conf_req.aw_valid);
            w_hi  += int'(bus.conf_req.w_valid);
            b_hs  += int'(bus.conf_req.b_ready & bus.conf_resp.b_valid);
            any_v += int'(bus.conf_req.aw_valid | bus.conf_req.w_valid | bus.conf_req.ar_valid);
            if (done || err) begin
                got_done = done;
                got_err  = err;
                cycles   = i + 1;
                start    = 1'b0;
                return;
            end
        end
        start = 1'b0;
        checks++;
        failures++;
        $display("FAIL run_timeout: got no done/err expected completion within 3000 cycles");
    endtask

    task automatic after_end(input string name);
        @(negedge clk);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_done_after"}, done, 0);
        chk({name, "_err_after"}, err, 0);
        repeat (3) @(negedge clk);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int   aw_hi, w_hi, b_hs, any_v, cycles;
        logic gd, ge;
        rst = 1'b1; start = 1'b0; mask = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valids", {bus.conf_req.aw_valid, bus.conf_req.w_valid, bus.conf_req.ar_valid,
                           bus.conf_req.b_ready, bus.conf_req.r_ready}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single poll completes; a start pulse while busy must be ignored.
        cfg(0, 0, 0, RespOkay, RespOkay);
        rdata_q = '{32'h0F};
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F); expect_ev(EV_AR, 32'h18); expect_ev(EV_DONE, 0);
        kick(8'h0F);
        run(2, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t1_done", gd, 1);
        chk("t1_aw_cycles", aw_hi, 1);
        chk("t1_w_cycles", w_hi, 1);
        after_end("t1");

        // Three polls, each separated by the idle gap.
        rdata_q = '{32'h01, 32'h7F, 32'hFF};
        ar_cyc_q.delete();
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'hFF);
        repeat (3) expect_ev(EV_AR, 32'h18);
        expect_ev(EV_DONE, 0);
        kick(8'hFF);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t2_done", gd, 1);
        after_end("t2");
        chk("t2_ar_count", ar_cyc_q.size(), 3);
        if (ar_cyc_q.size() == 3) begin
            chk("t2_ar_gap1", (ar_cyc_q[1] - ar_cyc_q[0]) >= 18, 1);
            chk("t2_ar_gap2", (ar_cyc_q[2] - ar_cyc_q[1]) >= 18, 1);
        end

        // Slow AW ready, immediate W ready.
        cfg(5, 0, 0, RespOkay, RespOkay);
        rdata_q = '{32'h3C};
        expect_ev(EV_W, 32'h3C); expect_ev(EV_AW, 32'h10); expect_ev(EV_AR, 32'h18); expect_ev(EV_DONE, 0);
        kick(8'h3C);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t3_done", gd, 1);
        chk("t3_aw_cycles", aw_hi, 6);
        chk("t3_w_cycles", w_hi, 1);
        chk("t3_b_count", b_hs, 1);
        after_end("t3");

        // SLVERR on write response: error pulse, no status read.
        cfg(0, 0, 0, RespSlvErr, RespOkay);
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F); expect_ev(EV_ERR, 0);
        kick(8'h0F);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t4_err", ge, 1);
        chk("t4_no_done", gd, 0);
        after_end("t4");

        // DECERR on read response.
        cfg(0, 0, 0, RespOkay, RespDecErr);
        rdata_q = '{32'h0F};
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F); expect_ev(EV_AR, 32'h18); expect_ev(EV_ERR, 0);
        kick(8'h0F);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t5_err", ge, 1);
        after_end("t5");

        // Empty mask: done one cycle after start, no bus traffic.
        cfg(0, 0, 0, RespOkay, RespOkay);
        expect_ev(EV_DONE, 0);
        kick(8'h00);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t6_done", gd, 1);
        chk("t6_latency", cycles, 1);
        chk("t6_no_valids", any_v, 0);
        after_end("t6");

        // Reset while AR is pending.
        cfg(0, 0, 3, RespOkay, RespOkay);
        rdata_q.delete();
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F);
        kick(8'h0F);
        gd = 0;
        for (int i = 0; i < 200 && !gd; i++) begin
            @(negedge clk);
            gd = bus.conf_req.ar_valid;
        end
        chk("t7_ar_seen", gd, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_outputs", {busy, done, err, bus.conf_req.aw_valid, bus.conf_req.w_valid,
                               bus.conf_req.ar_valid, bus.conf_req.b_ready, bus.conf_req.r_ready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        after_end("t7");

        // Polls that never complete.
        cfg(0, 0, 0, RespOkay, RespOkay);
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
        rdata_q = '{32'h07, 32'h07, 32'h07, 32'h07};
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F);
        repeat (4) expect_ev(EV_AR, 32'h18);
        expect_ev(EV_ERR, 0);
        kick(8'h0F);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t8_timeout_err", ge, 1);
`else
        rdata_q = '{32'h07, 32'h07, 32'h07, 32'h07, 32'h07, 32'h0F};
        expect_ev(EV_AW, 32'h10); expect_ev(EV_W, 32'h0F);
        repeat (6) expect_ev(EV_AR, 32'h18);
        expect_ev(EV_DONE, 0);
        kick(8'h0F);
        run(-5, aw_hi, w_hi, b_hs, any_v, cycles, gd, ge);
        chk("t8_no_timeout_done", gd, 1);
`endif
        after_end("t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
